// File: rtl/button_debounce_multi.sv
// -----------------------------------------------------------------------------
// button_debounce_multi
//
// Purpose:
//   N-channel push-button conditioner. Each channel synchronises its raw pin,
//   debounces it, and produces a clean level plus one-cycle press, release
//   and long-press pulses. The channels share no state.
//
// Ports:
//   clk           in   1     system clock
//   rst           in   1     synchronous reset, active low
//   button        in   N_CH  raw asynchronous button pins, 1 = pressed
//   level         out  N_CH  debounced button state
//   press         out  N_CH  1-cycle pulse on accepted 0->1 (and on auto-repeat)
//   release_pulse out  N_CH  1-cycle pulse on accepted 1->0
//                            ("release" is a reserved word in SystemVerilog)
//   long_press    out  N_CH  1-cycle pulse once per hold after LONG_CYCLES
//
// Build option:
//   BTN_AUTO_REPEAT_EN  when defined, press re-fires every REPEAT_CYCLES while
//                       the button stays held after long_press. When it is
//                       not defined, no repeat logic exists and REPEAT_CYCLES
//                       is only range-checked.
// -----------------------------------------------------------------------------
module button_debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 40000,
  parameter int CNT_W         = 16,
  parameter int LONG_CYCLES   = 5000000,
  parameter int REPEAT_CYCLES = 1000000,
  parameter int HOLD_W        = 23
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press
);

  // Last debounce count before a change is accepted.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  // Hold value one cycle before long_press fires.
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`else
  // Hold counter parks here after long_press so it can never fire twice.
  localparam logic [HOLD_W-1:0] LONG_SAT  = HOLD_W'(LONG_CYCLES);
`endif

  // Elaboration-time guard against counters too narrow for their targets.
  if (N_CH < 1 || STABLE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1 ||
      64'(STABLE_CYCLES - 1) >= (64'd1 << CNT_W) ||
      64'(LONG_CYCLES) >= (64'd1 << HOLD_W) ||
      64'(REPEAT_CYCLES) >= (64'd1 << HOLD_W)) begin : g_param_check
    $error("button_debounce_multi: parameter out of range");
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic              sync1_reg;
    logic              sync2_reg;
    logic              level_reg;
    logic              press_reg;
    logic              release_reg;
    logic              long_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [HOLD_W-1:0] hold_reg;
    logic              accept;
`ifdef BTN_AUTO_REPEAT_EN
    logic              repeat_reg;   // long_press already issued this hold
`endif

    // The synced sample has disagreed with level for STABLE_CYCLES samples:
    // level flips on this edge.
    assign accept = (sync2_reg != level_reg) && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
      if (!rst) begin
        sync1_reg   <= 1'b0;
        sync2_reg   <= 1'b0;
        level_reg   <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
        long_reg    <= 1'b0;
        cnt_reg     <= '0;
        hold_reg    <= '0;
`ifdef BTN_AUTO_REPEAT_EN
        repeat_reg  <= 1'b0;
`endif
      end else begin
        sync1_reg <= button[gi];
        sync2_reg <= sync1_reg;

        // Any agreeing sample restarts the window; no partial credit.
        if (sync2_reg == level_reg) begin
          cnt_reg <= '0;
        end else if (accept) begin
          cnt_reg   <= '0;
          level_reg <= ~level_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end

        // Edge pulses are registered alongside level so they coincide with
        // the first cycle level shows its new value.
        release_reg <= accept & level_reg;

        if (!level_reg) begin
          press_reg  <= accept;
          long_reg   <= 1'b0;
          hold_reg   <= '0;
`ifdef BTN_AUTO_REPEAT_EN
          repeat_reg <= 1'b0;
`endif
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          press_reg <= 1'b0;
          long_reg  <= 1'b0;
          if (!repeat_reg) begin
            if (hold_reg == LONG_LAST) begin
              // Suppressed if the release is accepted on the same edge.
              long_reg   <= ~accept;
              repeat_reg <= 1'b1;
              hold_reg   <= '0;
            end else begin
              hold_reg <= hold_reg + 1'b1;
            end
          end else begin
            if (hold_reg == REP_LAST) begin
              press_reg <= ~accept;   // no trailing repeat on release
              hold_reg  <= '0;
            end else begin
              hold_reg <= hold_reg + 1'b1;
            end
          end
`else
          press_reg <= 1'b0;
          long_reg  <= (hold_reg == LONG_LAST) & ~accept;
          if (hold_reg != LONG_SAT) begin
            hold_reg <= hold_reg + 1'b1;
          end
`endif
        end
      end
    end

    assign level[gi]         = level_reg;
    assign press[gi]         = press_reg;
    assign release_pulse[gi] = release_reg;
    assign long_press[gi]    = long_reg;
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_multi
//
// Purpose:
//   Directed self-checking bench for button_debounce_multi with a small
//   configuration (2 channels, 8-sample debounce, 32-cycle long press).
//   Inputs change 1 time unit after a rising edge; outputs are read there too,
//   so cycle c of a scenario is the c-th rising edge after the stimulus change.
//   Expected values are packed as {level, press, release, long_press}.
// -----------------------------------------------------------------------------
module tb_button_debounce_multi;

  localparam int N_CH          = 2;
  localparam int STABLE_CYCLES = 8;
  localparam int CNT_W         = 4;
  localparam int LONG_CYCLES   = 32;
  localparam int REPEAT_CYCLES = 8;
  localparam int HOLD_W        = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N_CH-1:0] button = '0;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] long_press;

  int n_checks = 0;
  int n_fail   = 0;

  button_debounce_multi #(
    .N_CH          (N_CH),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W),
    .LONG_CYCLES   (LONG_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES),
    .HOLD_W        (HOLD_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button        (button),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] obs();
    return {level, press, release_pulse, long_press};
  endfunction

  task automatic test_reset();
    logic [7:0] exp;
    exp = 8'h00;
    rst = 1'b0;
    button = 2'b00;
    tick();
    tick();
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL reset_hold got %b exp %b", obs(), exp);
    end
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got %b exp %b", c, obs(), exp);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    logic [7:0] exp;
    button = 2'b01;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = {(c >= 10) ? 2'b01 : 2'b00, (c == 10) ? 2'b01 : 2'b00, 2'b00, 2'b00};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL clean_press c=%0d got %b exp %b", c, obs(), exp);
      end
    end
    button = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = {(c < 10) ? 2'b01 : 2'b00, 2'b00, (c == 10) ? 2'b01 : 2'b00, 2'b00};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL clean_release c=%0d got %b exp %b", c, obs(), exp);
      end
    end
    $display("test_clean_press done");
  endtask

  task automatic test_bounce();
    logic [7:0] exp;
    // Ten toggles, 3 cycles apart: never stable long enough to be accepted.
    for (int k = 0; k < 10; k++) begin
      button[0] = (k % 2 == 0);
      for (int j = 0; j < 3; j++) begin
        tick();
        n_checks++;
        if (obs() !== 8'h00) begin
          n_fail++;
          $display("FAIL bounce k=%0d j=%0d got %b exp %b", k, j, obs(), 8'h00);
        end
      end
    end
    button = 2'b01;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = {(c >= 10) ? 2'b01 : 2'b00, (c == 10) ? 2'b01 : 2'b00, 2'b00, 2'b00};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL bounce_settle c=%0d got %b exp %b", c, obs(), exp);
      end
    end
    button = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = {(c < 10) ? 2'b01 : 2'b00, 2'b00, (c == 10) ? 2'b01 : 2'b00, 2'b00};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL bounce_release c=%0d got %b exp %b", c, obs(), exp);
      end
    end
    $display("test_bounce done");
  endtask

  // Level high for 30 cycles: two short of the long-press threshold.
  task automatic test_short_press();
    logic [7:0] exp;
    button = 2'b01;
    for (int c = 1; c <= 42; c++) begin
      tick();
      exp = {(c >= 10 && c < 40) ? 2'b01 : 2'b00, (c == 10) ? 2'b01 : 2'b00,
             (c == 40) ? 2'b01 : 2'b00, 2'b00};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL short_press c=%0d got %b exp %b", c, obs(), exp);
      end
      if (c == 30) button = 2'b00;
    end
    $display("test_short_press done");
  endtask

  // Press at c=10, long_press at c=42, release accepted at c=120.
  task automatic test_long_hold();
    logic [7:0] exp;
    logic       rep;
    button = 2'b01;
    for (int c = 1; c <= 124; c++) begin
      tick();
      rep = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rep = (c >= 50 && c < 120 && ((c - 42) % 8) == 0);
`endif
      exp = {(c >= 10 && c < 120) ? 2'b01 : 2'b00,
             (c == 10 || rep) ? 2'b01 : 2'b00,
             (c == 120) ? 2'b01 : 2'b00,
             (c == 42) ? 2'b01 : 2'b00};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL long_hold c=%0d got %b exp %b", c, obs(), exp);
      end
      if (c == 110) button = 2'b00;
    end
    $display("test_long_hold done");
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    button = 2'b01;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = {(c >= 10) ? 2'b01 : 2'b00, (c == 10) ? 2'b01 : 2'b00, 2'b00, 2'b00};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_press c=%0d got %b exp %b", c, obs(), exp);
      end
    end
    // Drop the button long enough for the debounce counter to reach 5.
    button = 2'b00;
    for (int c = 1; c <= 7; c++) begin
      tick();
      exp = {2'b01, 2'b00, 2'b00, 2'b00};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_count c=%0d got %b exp %b", c, obs(), exp);
      end
    end
    button = 2'b01;
    rst = 1'b0;
    tick();
    n_checks++;
    if (obs() !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_clear got %b exp %b", obs(), 8'h00);
    end
    rst = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = {(c >= 10) ? 2'b01 : 2'b00, (c == 10) ? 2'b01 : 2'b00, 2'b00, 2'b00};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_repress c=%0d got %b exp %b", c, obs(), exp);
      end
    end
    button = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = {(c < 10) ? 2'b01 : 2'b00, 2'b00, (c == 10) ? 2'b01 : 2'b00, 2'b00};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_release c=%0d got %b exp %b", c, obs(), exp);
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_both_channels();
    logic [7:0] exp;
    button = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = {(c >= 10) ? 2'b11 : 2'b00, (c == 10) ? 2'b11 : 2'b00, 2'b00, 2'b00};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL both_press c=%0d got %b exp %b", c, obs(), exp);
      end
    end
    // Channel 0 released now, channel 1 five cycles later.
    button = 2'b10;
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp = {(c < 10) ? 2'b11 : ((c < 15) ? 2'b10 : 2'b00), 2'b00,
             (c == 10) ? 2'b01 : ((c == 15) ? 2'b10 : 2'b00), 2'b00};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL both_release c=%0d got %b exp %b", c, obs(), exp);
      end
      if (c == 5) button = 2'b00;
    end
    $display("test_both_channels done");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_press();
    test_long_hold();
    test_reset_mid();
    test_both_channels();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
